// File: rtl/wg_intake_buffer.sv
// Workgroup intake: captures host descriptors into a small FIFO for the allocator, and tracks the
// outstanding wavefronts of each WG. Head is visible 1 cycle after capture; host holds valid while full.
module wg_intake_buffer #(
  parameter int WG_ID_WIDTH     = 6,
  parameter int WF_COUNT_WIDTH  = 4,
  parameter int WAVE_ITEM_WIDTH = 6,
  parameter int VGPR_ID_WIDTH   = 8,
  parameter int SGPR_ID_WIDTH   = 4,
  parameter int LDS_ID_WIDTH    = 8,
  parameter int GDS_ID_WIDTH    = 14,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_wg_valid,
  input  logic [WG_ID_WIDTH-1:0]     host_wg_id,
  input  logic [WF_COUNT_WIDTH-1:0]  host_num_wf,
  input  logic [WAVE_ITEM_WIDTH-1:0] host_wf_size,
  input  logic [VGPR_ID_WIDTH:0]     host_vgpr_size_total,
  input  logic [SGPR_ID_WIDTH:0]     host_sgpr_size_total,
  input  logic [LDS_ID_WIDTH:0]      host_lds_size_total,
  input  logic [GDS_ID_WIDTH:0]      host_gds_size_total,
  input  logic [VGPR_ID_WIDTH:0]     host_vgpr_size_per_wf,
  input  logic [SGPR_ID_WIDTH:0]     host_sgpr_size_per_wf,
  input  logic [MEM_ADDR_WIDTH-1:0]  host_start_pc,
  output logic                       inflight_wg_buffer_host_rcvd_ack,
  output logic                       alloc_wg_valid,
  input  logic                       alloc_ready,
  output logic [WG_ID_WIDTH-1:0]     alloc_wg_id,
  output logic [WF_COUNT_WIDTH-1:0]  alloc_num_wf,
  output logic [WAVE_ITEM_WIDTH-1:0] alloc_wf_size,
  output logic [VGPR_ID_WIDTH:0]     alloc_vgpr_size_total,
  output logic [SGPR_ID_WIDTH:0]     alloc_sgpr_size_total,
  output logic [LDS_ID_WIDTH:0]      alloc_lds_size_total,
  output logic [GDS_ID_WIDTH:0]      alloc_gds_size_total,
  output logic [VGPR_ID_WIDTH:0]     alloc_vgpr_size_per_wf,
  output logic [SGPR_ID_WIDTH:0]     alloc_sgpr_size_per_wf,
  output logic [MEM_ADDR_WIDTH-1:0]  alloc_start_pc,
  input  logic                       cu_wf_done,
  input  logic [WG_ID_WIDTH-1:0]     cu_wf_done_wg_id,
  output logic                       inflight_wg_buffer_host_wf_done,
  output logic [WG_ID_WIDTH-1:0]     inflight_wg_buffer_host_wf_done_wg_id,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       err
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int NUM_WG = 1 << WG_ID_WIDTH;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

  typedef struct packed {
    logic [WG_ID_WIDTH-1:0]     wg_id;
    logic [WF_COUNT_WIDTH-1:0]  num_wf;
    logic [WAVE_ITEM_WIDTH-1:0] wf_size;
    logic [VGPR_ID_WIDTH:0]     vgpr_size_total;
    logic [SGPR_ID_WIDTH:0]     sgpr_size_total;
    logic [LDS_ID_WIDTH:0]      lds_size_total;
    logic [GDS_ID_WIDTH:0]      gds_size_total;
    logic [VGPR_ID_WIDTH:0]     vgpr_size_per_wf;
    logic [SGPR_ID_WIDTH:0]     sgpr_size_per_wf;
    logic [MEM_ADDR_WIDTH-1:0]  start_pc;
  } wg_desc_t;

  wg_desc_t                    mem [DEPTH];
  wg_desc_t                    host_desc;
  wg_desc_t                    head;
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]    count;
  logic                        ack_q;
  logic                        done_q;
  logic [WG_ID_WIDTH-1:0]      done_id_q;
  logic [WF_COUNT_WIDTH-1:0]   cnt [NUM_WG];
  logic [WF_COUNT_WIDTH-1:0]   done_old;
  logic [WF_COUNT_WIDTH-1:0]   pop_old;
  logic                        capture;
  logic                        pop;

  assign host_desc = '{host_wg_id, host_num_wf, host_wf_size, host_vgpr_size_total,
                       host_sgpr_size_total, host_lds_size_total, host_gds_size_total,
                       host_vgpr_size_per_wf, host_sgpr_size_per_wf, host_start_pc};

  // The ack cycle still shows the old descriptor on the host bus, so it is never captured.
  assign capture = host_wg_valid && !ack_q && (count < DEPTH_CNT);
  assign alloc_wg_valid = (count != '0);
  assign pop = alloc_wg_valid && alloc_ready;
  assign head = alloc_wg_valid ? mem[rd_ptr] : '0;

  assign done_old = cnt[cu_wf_done_wg_id];
  assign pop_old  = cnt[head.wg_id];

  assign alloc_wg_id            = head.wg_id;
  assign alloc_num_wf           = head.num_wf;
  assign alloc_wf_size          = head.wf_size;
  assign alloc_vgpr_size_total  = head.vgpr_size_total;
  assign alloc_sgpr_size_total  = head.sgpr_size_total;
  assign alloc_lds_size_total   = head.lds_size_total;
  assign alloc_gds_size_total   = head.gds_size_total;
  assign alloc_vgpr_size_per_wf = head.vgpr_size_per_wf;
  assign alloc_sgpr_size_per_wf = head.sgpr_size_per_wf;
  assign alloc_start_pc         = head.start_pc;

  assign inflight_wg_buffer_host_rcvd_ack      = ack_q;
  assign inflight_wg_buffer_host_wf_done       = done_q;
  assign inflight_wg_buffer_host_wf_done_wg_id = done_id_q;
  assign fifo_count                            = count;

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= host_desc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_WG; i++) cnt[i] <= '0;
    end else begin
      ack_q <= capture;
      if (capture) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({capture, pop})
        2'b10:   count <= count + (FIFO_DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (FIFO_DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase

      done_q <= 1'b0;
      if (cu_wf_done) begin
        if (done_old == '0) begin
          err <= 1'b1;
        end else begin
          cnt[cu_wf_done_wg_id] <= done_old - WF_COUNT_WIDTH'(1);
          if (done_old == WF_COUNT_WIDTH'(1)) begin
            done_q    <= 1'b1;
            done_id_q <= cu_wf_done_wg_id;
          end
        end
      end

      // Placed after the decrement so a same-id pop overrides it.
      if (pop) begin
        cnt[head.wg_id] <= head.num_wf;
        if (pop_old != '0 || (cu_wf_done && cu_wf_done_wg_id == head.wg_id)) err <= 1'b1;
      end

      if (capture && host_num_wf == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wg_intake_buffer.sv
// Directed bench for wg_intake_buffer: handshake, backpressure, wrap, completion pulses, errors.
module tb_wg_intake_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wg_valid;
  logic [5:0]  host_wg_id;
  logic [3:0]  host_num_wf;
  logic [5:0]  host_wf_size;
  logic [8:0]  host_vgpr_size_total;
  logic [4:0]  host_sgpr_size_total;
  logic [8:0]  host_lds_size_total;
  logic [14:0] host_gds_size_total;
  logic [8:0]  host_vgpr_size_per_wf;
  logic [4:0]  host_sgpr_size_per_wf;
  logic [31:0] host_start_pc;
  logic        ack;
  logic        alloc_wg_valid;
  logic        alloc_ready;
  logic [5:0]  alloc_wg_id;
  logic [3:0]  alloc_num_wf;
  logic [5:0]  alloc_wf_size;
  logic [8:0]  alloc_vgpr_size_total;
  logic [4:0]  alloc_sgpr_size_total;
  logic [8:0]  alloc_lds_size_total;
  logic [14:0] alloc_gds_size_total;
  logic [8:0]  alloc_vgpr_size_per_wf;
  logic [4:0]  alloc_sgpr_size_per_wf;
  logic [31:0] alloc_start_pc;
  logic        cu_wf_done;
  logic [5:0]  cu_wf_done_wg_id;
  logic        wf_done;
  logic [5:0]  wf_done_wg_id;
  logic [2:0]  fifo_count;
  logic        err;

  int checks = 0;
  int passed = 0;

  logic [5:0] ids  [16];
  logic [3:0] nwfs [16];
  int         host_n;
  int         host_idx;
  int         acks;
  logic [5:0] popped [$];

  always #5 clk = ~clk;

  wg_intake_buffer dut (
    .clk(clk), .rst(rst),
    .host_wg_valid(host_wg_valid), .host_wg_id(host_wg_id), .host_num_wf(host_num_wf),
    .host_wf_size(host_wf_size), .host_vgpr_size_total(host_vgpr_size_total),
    .host_sgpr_size_total(host_sgpr_size_total), .host_lds_size_total(host_lds_size_total),
    .host_gds_size_total(host_gds_size_total), .host_vgpr_size_per_wf(host_vgpr_size_per_wf),
    .host_sgpr_size_per_wf(host_sgpr_size_per_wf), .host_start_pc(host_start_pc),
    .inflight_wg_buffer_host_rcvd_ack(ack),
    .alloc_wg_valid(alloc_wg_valid), .alloc_ready(alloc_ready),
    .alloc_wg_id(alloc_wg_id), .alloc_num_wf(alloc_num_wf), .alloc_wf_size(alloc_wf_size),
    .alloc_vgpr_size_total(alloc_vgpr_size_total), .alloc_sgpr_size_total(alloc_sgpr_size_total),
    .alloc_lds_size_total(alloc_lds_size_total), .alloc_gds_size_total(alloc_gds_size_total),
    .alloc_vgpr_size_per_wf(alloc_vgpr_size_per_wf), .alloc_sgpr_size_per_wf(alloc_sgpr_size_per_wf),
    .alloc_start_pc(alloc_start_pc),
    .cu_wf_done(cu_wf_done), .cu_wf_done_wg_id(cu_wf_done_wg_id),
    .inflight_wg_buffer_host_wf_done(wf_done),
    .inflight_wg_buffer_host_wf_done_wg_id(wf_done_wg_id),
    .fifo_count(fifo_count), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Host model: present descriptor host_idx with fields derived from its id.
  task automatic present;
    if (host_idx < host_n) begin
      host_wg_valid         = 1'b1;
      host_wg_id            = ids[host_idx];
      host_num_wf           = nwfs[host_idx];
      host_wf_size          = ids[host_idx] ^ 6'h2a;
      host_vgpr_size_total  = {3'b101, ids[host_idx]};
      host_sgpr_size_total  = 5'h11;
      host_lds_size_total   = {3'b010, ids[host_idx]};
      host_gds_size_total   = {9'h1ab, ids[host_idx]};
      host_vgpr_size_per_wf = 9'h021;
      host_sgpr_size_per_wf = 5'h03;
      host_start_pc         = 32'hA000_0000 + 32'(ids[host_idx]);
    end else begin
      host_wg_valid = 1'b0;
    end
  endtask

  task automatic start_stream(input int n);
    host_n   = n;
    host_idx = 0;
    acks     = 0;
    popped.delete();
    present();
  endtask

  // One clock: log the head the allocator takes at this edge, then react to ack like a host.
  task automatic cycle;
    if (alloc_wg_valid && alloc_ready) popped.push_back(alloc_wg_id);
    tick();
    if (ack) begin
      acks++;
      host_idx++;
      present();
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    host_wg_valid = 1'b0;
    alloc_ready = 1'b0;
    cu_wf_done = 1'b0;
    cu_wf_done_wg_id = '0;
    host_n = 0;
    host_idx = 0;
    present();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack got %0b want 0", ack); else passed++;
    checks++; if (alloc_wg_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", alloc_wg_valid); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else passed++;
    checks++; if (wf_done !== 1'b0) $display("FAIL reset_done got %0b want 0", wf_done); else passed++;
    checks++; if (alloc_start_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", alloc_start_pc); else passed++;
  endtask

  task automatic test_single;
    do_reset();
    ids[0] = 6'd5; nwfs[0] = 4'd3;
    alloc_ready = 1'b1;
    start_stream(1);
    cycle();
    checks++; if (ack !== 1'b1) $display("FAIL single_ack got %0b want 1", ack); else passed++;
    checks++; if (alloc_wg_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", alloc_wg_valid); else passed++;
    checks++; if (alloc_wg_id !== 6'd5) $display("FAIL single_id got %0d want 5", alloc_wg_id); else passed++;
    checks++; if (alloc_num_wf !== 4'd3) $display("FAIL single_nwf got %0d want 3", alloc_num_wf); else passed++;
    checks++; if (alloc_start_pc !== 32'hA000_0005) $display("FAIL single_pc got %h want a0000005", alloc_start_pc); else passed++;
    checks++; if (alloc_wf_size !== 6'h2f) $display("FAIL single_wfsize got %h want 2f", alloc_wf_size); else passed++;
    checks++; if (alloc_gds_size_total !== 15'h6ac5) $display("FAIL single_gds got %h want 6ac5", alloc_gds_size_total); else passed++;
    checks++; if (fifo_count !== 3'd1) $display("FAIL single_count1 got %0d want 1", fifo_count); else passed++;
    cycle();
    checks++; if (ack !== 1'b0) $display("FAIL single_ack_pulse got %0b want 0", ack); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL single_count0 got %0d want 0", fifo_count); else passed++;
    alloc_ready = 1'b0;
    cu_wf_done = 1'b1; cu_wf_done_wg_id = 6'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wf_done !== (i == 2)) $display("FAIL single_done%0d got %0b want %0b", i, wf_done, (i == 2)); else passed++;
    end
    checks++; if (wf_done_wg_id !== 6'd5) $display("FAIL single_done_id got %0d want 5", wf_done_wg_id); else passed++;
    cu_wf_done = 1'b0;
    tick();
    checks++; if (wf_done !== 1'b0) $display("FAIL single_done_once got %0b want 0", wf_done); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL single_err got %0b want 0", err); else passed++;
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int i = 0; i < 5; i++) begin ids[i] = 6'(10 + i); nwfs[i] = 4'd1; end
    start_stream(5);
    repeat (12) cycle();
    checks++; if (acks !== 4) $display("FAIL bp_acks got %0d want 4", acks); else passed++;
    checks++; if (fifo_count !== 3'd4) $display("FAIL bp_full got %0d want 4", fifo_count); else passed++;
    checks++; if (host_wg_valid !== 1'b1 || host_wg_id !== 6'd14) $display("FAIL bp_held got id %0d want 14", host_wg_id); else passed++;
    alloc_ready = 1'b1;
    for (int c = 0; c < 30 && popped.size() < 5; c++) cycle();
    checks++; if (popped.size() !== 5) $display("FAIL bp_drain got %0d pops want 5", popped.size()); else passed++;
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 6'(10 + i)) $display("FAIL bp_order%0d got %0d want %0d", i, popped[i], 10 + i); else passed++;
    end
    checks++; if (acks !== 5) $display("FAIL bp_acks5 got %0d want 5", acks); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL bp_empty got %0d want 0", fifo_count); else passed++;
    alloc_ready = 1'b0;
  endtask

  task automatic test_held_valid;
    do_reset();
    ids[0] = 6'd20; nwfs[0] = 4'd1;
    host_n = 1; host_idx = 0;
    present();
    tick();
    checks++; if (ack !== 1'b1) $display("FAIL held_ack got %0b want 1", ack); else passed++;
    // Host keeps valid and data through the ack cycle, then drops it.
    tick();
    checks++; if (fifo_count !== 3'd1) $display("FAIL held_count got %0d want 1", fifo_count); else passed++;
    checks++; if (ack !== 1'b0) $display("FAIL held_ack_once got %0b want 0", ack); else passed++;
    host_wg_valid = 1'b0;
    tick();
    tick();
    checks++; if (fifo_count !== 3'd1) $display("FAIL held_count_late got %0d want 1", fifo_count); else passed++;
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 10; i++) begin ids[i] = 6'(30 + i); nwfs[i] = 4'd1; end
    start_stream(10);
    for (int c = 0; c < 10 && acks < 2; c++) cycle();
    cycle();
    checks++; if (fifo_count !== 3'd2) $display("FAIL wrap_pre got %0d want 2", fifo_count); else passed++;
    alloc_ready = 1'b1;
    cycle();
    checks++; if (fifo_count !== 3'd2) $display("FAIL wrap_pushpop got %0d want 2", fifo_count); else passed++;
    checks++; if (ack !== 1'b1) $display("FAIL wrap_pushpop_ack got %0b want 1", ack); else passed++;
    for (int c = 0; c < 60 && popped.size() < 10; c++) cycle();
    checks++; if (popped.size() !== 10) $display("FAIL wrap_pops got %0d want 10", popped.size()); else passed++;
    for (int i = 0; i < 10 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 6'(30 + i)) $display("FAIL wrap_order%0d got %0d want %0d", i, popped[i], 30 + i); else passed++;
    end
    checks++; if (err !== 1'b0) $display("FAIL wrap_err got %0b want 0", err); else passed++;
    alloc_ready = 1'b0;
  endtask

  task automatic test_interleaved;
    do_reset();
    ids[0] = 6'd1; nwfs[0] = 4'd2;
    ids[1] = 6'd2; nwfs[1] = 4'd1;
    alloc_ready = 1'b1;
    start_stream(2);
    for (int c = 0; c < 20 && popped.size() < 2; c++) cycle();
    checks++; if (popped.size() !== 2) $display("FAIL il_pops got %0d want 2", popped.size()); else passed++;
    alloc_ready = 1'b0;
    cu_wf_done = 1'b1; cu_wf_done_wg_id = 6'd1;
    tick();
    checks++; if (wf_done !== 1'b0) $display("FAIL il_done_a got %0b want 0", wf_done); else passed++;
    cu_wf_done_wg_id = 6'd2;
    tick();
    checks++; if (wf_done !== 1'b1 || wf_done_wg_id !== 6'd2) $display("FAIL il_done_b got %0b/%0d want 1/2", wf_done, wf_done_wg_id); else passed++;
    cu_wf_done_wg_id = 6'd1;
    tick();
    checks++; if (wf_done !== 1'b1 || wf_done_wg_id !== 6'd1) $display("FAIL il_done_c got %0b/%0d want 1/1", wf_done, wf_done_wg_id); else passed++;
    cu_wf_done = 1'b0;
    tick();
    checks++; if (wf_done !== 1'b0) $display("FAIL il_done_end got %0b want 0", wf_done); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL il_err got %0b want 0", err); else passed++;
  endtask

  task automatic test_errors;
    do_reset();
    cu_wf_done = 1'b1; cu_wf_done_wg_id = 6'd9;
    tick();
    checks++; if (err !== 1'b1) $display("FAIL err_stray got %0b want 1", err); else passed++;
    checks++; if (wf_done !== 1'b0) $display("FAIL err_stray_pulse got %0b want 0", wf_done); else passed++;
    cu_wf_done = 1'b0;
    ids[0] = 6'd40; nwfs[0] = 4'd1;
    host_n = 1; host_idx = 0;
    present();
    tick();
    checks++; if (err !== 1'b1) $display("FAIL err_sticky got %0b want 1", err); else passed++;
    checks++; if (ack !== 1'b1 || fifo_count !== 3'd1) $display("FAIL err_queued got ack %0b count %0d want 1/1", ack, fifo_count); else passed++;
    rst = 1'b1;
    host_wg_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (err !== 1'b0) $display("FAIL err_rst got %0b want 0", err); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL err_rst_count got %0d want 0", fifo_count); else passed++;
    checks++; if (ack !== 1'b0) $display("FAIL err_rst_ack got %0b want 0", ack); else passed++;
    checks++; if (alloc_wg_valid !== 1'b0) $display("FAIL err_rst_valid got %0b want 0", alloc_wg_valid); else passed++;
    ids[0] = 6'd41; nwfs[0] = 4'd0;
    host_n = 1; host_idx = 0;
    present();
    tick();
    host_wg_valid = 1'b0;
    checks++; if (err !== 1'b1) $display("FAIL err_zero_nwf got %0b want 1", err); else passed++;
    checks++; if (fifo_count !== 3'd1) $display("FAIL err_zero_queued got %0d want 1", fifo_count); else passed++;
    alloc_ready = 1'b1;
    tick();
    tick();
    checks++; if (fifo_count !== 3'd0 || wf_done !== 1'b0) $display("FAIL err_zero_pop got count %0d done %0b want 0/0", fifo_count, wf_done); else passed++;
    alloc_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_held_valid();
    test_wrap();
    test_interleaved();
    test_errors();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
